tmds_period_sched: RTL and testbench

TMDS_PERIOD_SCHED -- requirements
Module: tmds_period_sched

---
 rtl/tmds_period_sched.sv | 175 +++++++++++++++++
 tb/tb_tmds_period_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tmds_period_sched.sv
// tmds_period_sched: delays raw video timing/pixel data by LAT cycles and
// schedules the HDMI data-island-free video period sequence
// (CTRL -> PREAMBLE -> GUARD -> ACTIVE) aligned to the delayed data enable.
module tmds_period_sched #(
  parameter int LAT = 10
) (
  input  logic        pixel_clk,
  input  logic        n_rst,
  input  logic        hdmi_mode,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] rgb_in,
  input  logic        err_clr,
  output logic [23:0] rgb_out,
  output logic        active_video,
  output logic        guard_band,
  output logic        ch0_d0,
  output logic        ch0_d1,
  output logic        ch1_d0,
  output logic        ch1_d1,
  output logic        ch2_d0,
  output logic        ch2_d1,
  output logic        short_blank,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_CTRL   = 2'd0,
    ST_PRE    = 2'd1,
    ST_GUARD  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Minimum blank run (cycles of de_in=0) that leaves room for 8 preamble
  // plus 2 guard-band cycles ahead of the video period.
  localparam logic [5:0] MIN_BLANK = 6'd22;

  // Timing/pixel pipeline. LAT stages feed the output registers, so a sample
  // taken at edge k reaches the ports after edge k+LAT.
  logic [LAT-1:0] de_pipe_q;
  logic [LAT-1:0] hs_pipe_q;
  logic [LAT-1:0] vs_pipe_q;
  logic [23:0]    rgb_pipe_q [LAT];

  logic       de_prev_q;
  logic [5:0] blank_q, blank_d;
  logic [3:0] seq_q, seq_d;
  state_t     state_q, state_d;
  logic       short_q, short_d;

  logic [23:0] rgb_out_q;
  logic        active_q, guard_q, hs_out_q, vs_out_q, pre_q;

  logic rise, long_blank, start_seq, de_out_next;

  // Shift timing and pixel data through the delay pipeline.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      for (int i = 0; i < LAT; i++) rgb_pipe_q[i] <= '0;
    end else begin
      de_pipe_q <= {de_pipe_q[LAT-2:0], de_in};
      hs_pipe_q <= {hs_pipe_q[LAT-2:0], hsync_in};
      vs_pipe_q <= {vs_pipe_q[LAT-2:0], vsync_in};
      rgb_pipe_q[0] <= rgb_in;
      for (int i = 1; i < LAT; i++) rgb_pipe_q[i] <= rgb_pipe_q[i-1];
    end
  end

  // Edge detect, blank length measurement and sticky short-blank flag.
  always_comb begin
    rise        = de_in & ~de_prev_q;
    long_blank  = (blank_q >= MIN_BLANK);
    start_seq   = rise & hdmi_mode & long_blank;
    de_out_next = de_pipe_q[LAT-1];

    blank_d = blank_q;
    if (de_in)
      blank_d = 6'd0;
    else if (blank_q != 6'd63)
      blank_d = blank_q + 6'd1;

    short_d = short_q;
    if (err_clr)
      short_d = 1'b0;
    else if (rise && hdmi_mode && !long_blank)
      short_d = 1'b1;
  end

  // Period sequencer next state. Rising edges are ignored while the
  // preamble/guard sequence is running; hdmi_mode only matters at a rise.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    case (state_q)
      ST_CTRL: begin
        if (start_seq) begin
          state_d = ST_PRE;
          seq_d   = 4'd0;
        end else if (de_out_next) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_PRE: begin
        seq_d = seq_q + 4'd1;
        if (seq_q == 4'd7) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        seq_d = seq_q + 4'd1;
        if (seq_q == 4'd9) begin
          seq_d   = 4'd0;
          state_d = de_out_next ? ST_ACTIVE : ST_CTRL;
        end
      end
      ST_ACTIVE: begin
        if (start_seq) begin
          state_d = ST_PRE;
          seq_d   = 4'd0;
        end else if (!de_out_next) begin
          state_d = ST_CTRL;
        end
      end
      default: begin
        state_d = ST_CTRL;
        seq_d   = 4'd0;
      end
    endcase
  end

  // Control state and registered outputs decoded from the next state.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      de_prev_q <= 1'b0;
      blank_q   <= '0;
      seq_q     <= '0;
      state_q   <= ST_CTRL;
      short_q   <= 1'b0;
      rgb_out_q <= '0;
      active_q  <= 1'b0;
      guard_q   <= 1'b0;
      pre_q     <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
    end else begin
      de_prev_q <= de_in;
      blank_q   <= blank_d;
      seq_q     <= seq_d;
      state_q   <= state_d;
      short_q   <= short_d;
      rgb_out_q <= rgb_pipe_q[LAT-1];
      active_q  <= (state_d == ST_ACTIVE);
      guard_q   <= (state_d == ST_GUARD);
      pre_q     <= (state_d == ST_PRE);
      hs_out_q  <= hs_pipe_q[LAT-1];
      vs_out_q  <= vs_pipe_q[LAT-1];
    end
  end

  assign rgb_out      = rgb_out_q;
  assign active_video = active_q;
  assign guard_band   = guard_q;
  assign ch0_d0       = hs_out_q;
  assign ch0_d1       = vs_out_q;
  // Video preamble is CTL0..3 = 1,0,0,0; every other period drives all zero.
  assign ch1_d0       = pre_q;
  assign ch1_d1       = 1'b0;
  assign ch2_d0       = 1'b0;
  assign ch2_d1       = 1'b0;
  assign short_blank  = short_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_tmds_period_sched.sv
// Directed bench for tmds_period_sched: DVI, HDMI preamble/guard, short blank,
// err_clr priority, sync/pixel delay and reset in the middle of a preamble.
module tb_tmds_period_sched;

  logic        pixel_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        hdmi_mode = 1'b0;
  logic        de_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        err_clr = 1'b0;
  logic [23:0] rgb_out;
  logic        active_video, guard_band;
  logic        ch0_d0, ch0_d1, ch1_d0, ch1_d1, ch2_d0, ch2_d1;
  logic        short_blank;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic sb_exp = 1'b0;

  tmds_period_sched #(.LAT(10)) dut (
    .pixel_clk(pixel_clk), .n_rst(n_rst), .hdmi_mode(hdmi_mode),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .err_clr(err_clr), .rgb_out(rgb_out),
    .active_video(active_video), .guard_band(guard_band),
    .ch0_d0(ch0_d0), .ch0_d1(ch0_d1), .ch1_d0(ch1_d0), .ch1_d1(ch1_d1),
    .ch2_d0(ch2_d0), .ch2_d1(ch2_d1), .short_blank(short_blank),
    .state_o(state_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int e, input int k);
    logic [7:0] b;
    b = 8'(e);
    return (e == k) ? 24'hA5C3F0 : {b, ~b, 8'h3C};
  endfunction

  // One directed run of a blank period, a de pulse of de_len edges starting at
  // edge k, then tail idle edges. Expected port values after each edge e are
  // derived from the hand timeline: preamble k..k+7, guard k+8..k+9, active
  // from k+10 for de_len cycles; syncs appear 10 edges after they are driven.
  task automatic phase(input string name, input logic hdmi, input logic hdmi_late,
                       input int k, input int de_len, input int tail,
                       input int hs_j, input int vs_j, input bit pre, input bit sets_short);
    int n;
    logic [1:0] st;
    n = k + de_len + tail;
    for (int e = 0; e < n; e++) begin
      hdmi_mode = (e <= k) ? hdmi : hdmi_late;
      de_in     = (e >= k) && (e < k + de_len);
      hsync_in  = (hs_j >= 0) && (e >= hs_j) && (e <= hs_j + 43);
      vsync_in  = (vs_j >= 0) && (e >= vs_j) && (e <= vs_j + 43);
      rgb_in    = pix(e, k);
      tick();
      if (sets_short && e == k) sb_exp = 1'b1;
      if (pre && e >= k && e <= k + 7)               st = 2'd1;
      else if (pre && (e == k + 8 || e == k + 9))    st = 2'd2;
      else if (e >= k + 10 && e <= k + de_len + 9)   st = 2'd3;
      else                                           st = 2'd0;
      chk({name, " state"},  state_o, st);
      chk({name, " active"}, active_video, st == 2'd3);
      chk({name, " guard"},  guard_band, st == 2'd2);
      chk({name, " ctl"},    {ch1_d0, ch1_d1, ch2_d0, ch2_d1}, (st == 2'd1) ? 4'b1000 : 4'b0000);
      chk({name, " hsync"},  ch0_d0, (hs_j >= 0) && (e >= hs_j + 10) && (e <= hs_j + 53));
      chk({name, " vsync"},  ch0_d1, (vs_j >= 0) && (e >= vs_j + 10) && (e <= vs_j + 53));
      chk({name, " short"},  short_blank, sb_exp);
      if (e >= 10) chk({name, " rgb"}, rgb_out, pix(e - 10, k));
    end
    $display("phase %s: %0d edges, checks so far %0d", name, n, n_checks);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset outs", {rgb_out, active_video, guard_band, ch0_d0, ch0_d1, ch1_d0,
                       ch1_d1, ch2_d0, ch2_d1, short_blank, state_o}, '0);
    n_rst = 1'b1;

    // DVI: no preamble/guard, active from k+10; vsync delay
    phase("dvi", 1'b0, 1'b0, 30, 20, 12, -1, 0, 1'b0, 1'b0);
    // HDMI long blank: preamble/guard, hsync across preamble, hdmi_mode dropped mid-sequence
    phase("hdmi", 1'b1, 1'b0, 30, 20, 12, 5, -1, 1'b1, 1'b0);
    // HDMI short blank (12 tail + 3 = 15): no preamble, sticky flag set
    phase("short", 1'b1, 1'b1, 3, 20, 12, -1, -1, 1'b0, 1'b1);

    // err_clr clears the sticky flag on the next edge
    de_in = 1'b0; err_clr = 1'b1;
    tick();
    sb_exp = 1'b0;
    chk("errclr clear", short_blank, 1'b0);
    err_clr = 1'b0;
    tick();
    chk("errclr stays", short_blank, 1'b0);
    // clear wins over a simultaneous short-blank rise
    de_in = 1'b1; hdmi_mode = 1'b1; err_clr = 1'b1;
    tick();
    chk("errclr prio", short_blank, 1'b0);
    chk("errclr prio state", state_o, 2'd0);
    err_clr = 1'b0; de_in = 1'b0;
    tick();
    chk("errclr after", short_blank, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    chk("idle state", state_o, 2'd0);
    $display("err_clr sequence done");

    // Reset in the middle of a preamble
    de_in = 1'b1; hdmi_mode = 1'b1;
    tick();                                   // edge k
    for (int i = 0; i < 3; i++) tick();       // edge k+3
    chk("pre before rst", state_o, 2'd1);
    chk("pre before rst ctl", ch1_d0, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("async reset outs", {rgb_out, active_video, guard_band, ch0_d0, ch0_d1, ch1_d0,
                             ch1_d1, ch2_d0, ch2_d1, short_blank, state_o}, '0);
    #1 n_rst = 1'b1;
    tick();                                   // edge r: rise with blank 0
    chk("post rst short", short_blank, 1'b1);
    chk("post rst state", state_o, 2'd0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("post rst no pre", {state_o, ch1_d0, guard_band, active_video}, 5'b0);
    end
    tick();                                   // edge r+10
    chk("post rst active", state_o, 2'd3);
    chk("post rst av", active_video, 1'b1);
    $display("reset sequence done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
